if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble instruction (ADDI x0,x0,0).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port stall, input, 1 bit: hazard stall from the hazard detection unit.
REQ-006 SHALL have port IF_flush, input, 1 bit: taken branch/jump redirect from decode.
REQ-007 SHALL have port EA, input, 32 bits: redirect target from decode.
REQ-008 SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-009 SHALL have port imem_addr, output, 32 bits: request address.
REQ-010 SHALL have port imem_ack, input, 1 bit: response valid, one cycle or more after the request.
REQ-011 SHALL have port imem_rdata, input, 32 bits: instruction word, valid with imem_ack.
REQ-012 SHALL have port IF_PC, output, 32 bits: PC of the instruction held in the IF/ID register.
REQ-013 SHALL have ports opcode_ID [6:0], rd_ID [4:0], funct3 [2:0], rs1_ID [4:0], rs2_ID [4:0], funct7 [6:0], all outputs: fields of the IF/ID instruction, bits [6:0], [11:7], [14:12], [19:15], [24:20], [31:25].
REQ-014 SHALL have port IF_flush_out, output, 1 bit: the IF/ID register holds a flush bubble.
REQ-015 SHALL have port en, output, 1 bit: the IF/ID register holds a valid fetched instruction.

Function
REQ-016 SHALL implement FSM states FETCH (request outstanding), WAIT_ID (word held, decode stalled) and DISCARD (stale response pending after a redirect).
REQ-017 SHALL, in FETCH, drive imem_req=1 and imem_addr=PC, holding both stable until imem_ack.
REQ-018 SHALL, on imem_ack in FETCH with stall=0 and IF_flush=0, load the IF/ID register with {PC, imem_rdata}, set en=1 and PC<=PC+4 (mod 2^32, wrapping at 32'hFFFF_FFFC to 0), and stay in FETCH; the new request follows the next cycle.
REQ-019 SHALL hold the IF/ID register and PC while stall=1; an imem_ack arriving during the stall SHALL be captured in a one-entry skid buffer, with a move to WAIT_ID and imem_req=0.
REQ-020 SHALL, in WAIT_ID when stall falls, move the skid word into IF/ID, set PC<=PC+4 and return to FETCH.
REQ-021 SHALL, on IF_flush=1, set PC<=EA, load IF/ID with NOP_INSTR, set en=0 and IF_flush_out=1 for exactly one cycle, and empty the skid buffer; IF_flush has priority over stall and over imem_ack.
REQ-022 SHALL, on IF_flush with a request outstanding and no imem_ack that cycle, enter DISCARD, drop the next imem_ack, then return to FETCH at EA; a redirect seen while in DISCARD SHALL update the target only.
REQ-023 SHALL, while no word is available (FETCH without ack), load IF/ID with NOP_INSTR and en=0 unless stall=1.

Reset
REQ-024 SHALL, while rst_n=0: PC=RESET_PC, state=FETCH, IF/ID=NOP_INSTR, IF_PC=0, en=0, IF_flush_out=0, skid empty, imem_req=0.
REQ-025 SHALL issue the first request in the first cycle after rst_n rises; a response to any request outstanding at reset SHALL be dropped (the block enters DISCARD if reset occurred while imem_req=1).

Structure
REQ-026 SHALL take the opcode constants, NOP_INSTR and the state encoding from the shared pipeline package pipe_pkg.
REQ-027 SHALL have the skid buffer as sub-module fetch_skid (one entry, valid/data, load/clear).

Verification
REQ-028 SHALL verify: reset, then 1-cycle-ack memory returning 32'h0010_0093 at 0 -> IF_PC=0, opcode_ID=7'h13, rd_ID=1, en=1; next imem_addr=4.
REQ-029 SHALL verify: stall=1 for 3 cycles with ack at address 8 -> IF/ID unchanged, imem_req=0 after the ack, word at 8 appears the cycle after stall falls.
REQ-030 SHALL verify: IF_flush=1 with EA=32'h40 and ack the same cycle -> IF_flush_out=1 one cycle, opcode_ID=7'h13, next imem_addr=32'h40.
REQ-031 SHALL verify: IF_flush with EA=32'h80 while a 3-cycle-latency request at 32'h10 is pending -> response dropped, next request at 32'h80.
REQ-032 SHALL verify: PC at 32'hFFFF_FFFC acked -> next imem_addr=0.
REQ-033 SHALL verify: rst_n low mid-request -> all outputs at reset values at once; the stale ack is ignored.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: RV32 opcode values, the bubble instruction
// and the fetch FSM state encoding.
package pipe_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_REG    = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F
  } opcode_t;

  // ADDI x0,x0,0
  localparam logic [31:0] PIPE_NOP = {25'd0, OP_IMM};

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT_ID = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction word that arrived while
// decode was stalled.
module fetch_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] data,
  output logic        valid,
  output logic [31:0] word
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     valid <= 1'b0;
    else if (clear) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (load) word <= data;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: drives a request/ack instruction memory, handles
// decode stalls through a skid buffer and drops responses made stale by a redirect.
module if_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = PIPE_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        IF_flush,
  input  logic [31:0] EA,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC,
  output logic [6:0]  opcode_ID,
  output logic [4:0]  rd_ID,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1_ID,
  output logic [4:0]  rs2_ID,
  output logic [6:0]  funct7,
  output logic        IF_flush_out,
  output logic        en
);

  fetch_state_t state, state_nx;
  logic [31:0]  pc, pc_nx;
  logic [31:0]  ifid_pc, ifid_pc_nx;
  logic [31:0]  ifid_ir, ifid_ir_nx;
  logic         en_nx, flush_out_nx;
  logic         boot, pend, drop_stale;
  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_word;

  fetch_skid u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clear),
    .data  (imem_rdata),
    .valid (skid_valid),
    .word  (skid_word)
  );

  // pend survives reset on purpose: in the first cycle after reset it tells
  // whether a response to a pre-reset request is still on its way.
  always_ff @(posedge clk) begin
    pend <= imem_ack ? 1'b0 : (pend | imem_req);
  end

  assign drop_stale = boot & pend;
  assign imem_req   = rst_n & (state == FETCH);
  assign imem_addr  = pc;

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    ifid_pc_nx   = ifid_pc;
    ifid_ir_nx   = ifid_ir;
    en_nx        = en;
    flush_out_nx = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    if (IF_flush) begin
      pc_nx        = EA;
      ifid_pc_nx   = pc;
      ifid_ir_nx   = NOP_INSTR;
      en_nx        = 1'b0;
      flush_out_nx = 1'b1;
      skid_clear   = 1'b1;
      case (state)
        WAIT_ID: state_nx = FETCH;
        default: state_nx = imem_ack ? FETCH : DISCARD;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack && !drop_stale) begin
            if (stall) begin
              skid_load = 1'b1;
              state_nx  = WAIT_ID;
            end else begin
              ifid_pc_nx = pc;
              ifid_ir_nx = imem_rdata;
              en_nx      = 1'b1;
              pc_nx      = pc + 32'd4;
            end
          end else begin
            if (!stall) begin
              ifid_ir_nx = NOP_INSTR;
              en_nx      = 1'b0;
            end
            if (drop_stale && !imem_ack) state_nx = DISCARD;
          end
        end
        WAIT_ID: begin
          if (!stall && skid_valid) begin
            ifid_pc_nx = pc;
            ifid_ir_nx = skid_word;
            en_nx      = 1'b1;
            pc_nx      = pc + 32'd4;
            skid_clear = 1'b1;
            state_nx   = FETCH;
          end
        end
        DISCARD: begin
          if (!stall) begin
            ifid_ir_nx = NOP_INSTR;
            en_nx      = 1'b0;
          end
          if (imem_ack) state_nx = FETCH;
        end
        default: state_nx = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      ifid_pc      <= 32'd0;
      ifid_ir      <= NOP_INSTR;
      en           <= 1'b0;
      IF_flush_out <= 1'b0;
      boot         <= 1'b1;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      ifid_pc      <= ifid_pc_nx;
      ifid_ir      <= ifid_ir_nx;
      en           <= en_nx;
      IF_flush_out <= flush_out_nx;
      boot         <= 1'b0;
    end
  end

  assign IF_PC     = ifid_pc;
  assign opcode_ID = ifid_ir[6:0];
  assign rd_ID     = ifid_ir[11:7];
  assign funct3    = ifid_ir[14:12];
  assign rs1_ID    = ifid_ir[19:15];
  assign rs2_ID    = ifid_ir[24:20];
  assign funct7    = ifid_ir[31:25];

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: variable-latency memory responder plus an
// instruction-stream reference model (expected PC sequence and word contents).
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        IF_flush = 1'b0;
  logic [31:0] EA = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] IF_PC;
  logic [6:0]  opcode_ID;
  logic [4:0]  rd_ID;
  logic [2:0]  funct3;
  logic [4:0]  rs1_ID;
  logic [4:0]  rs2_ID;
  logic [6:0]  funct7;
  logic        IF_flush_out;
  logic        en;

  if_fetch u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .IF_flush     (IF_flush),
    .EA           (EA),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .IF_PC        (IF_PC),
    .opcode_ID    (opcode_ID),
    .rd_ID        (rd_ID),
    .funct3       (funct3),
    .rs1_ID       (rs1_ID),
    .rs2_ID       (rs2_ID),
    .funct7       (funct7),
    .IF_flush_out (IF_flush_out),
    .en           (en)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  int          n_consumed = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] exp_pc = 32'd0;
  logic        chk_on = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'd0) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ir_now();
    return {funct7, rs2_ID, rs1_ID, funct3, rd_ID, opcode_ID};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory: accepts a request mid-cycle when idle, answers mem_lat cycles later
  // with a one-cycle ack; a response is delivered even across a DUT reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!mem_busy && imem_req) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = mem_lat;
      end
      @(posedge clk);
      #2;
      if (imem_ack) begin
        imem_ack = 1'b0;
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = word_at(mem_addr);
        end
      end
    end
  end

  // One clock: drive inputs, sample IF/ID before the edge, check the stream after it.
  task automatic tick(input logic s, input logic f, input logic [31:0] ea);
    logic p_en, p_hold;
    logic [31:0] p_pc, p_ir;
    stall = s;
    IF_flush = f;
    EA = ea;
    @(negedge clk);
    p_en = en;
    p_pc = IF_PC;
    p_ir = ir_now();
    p_hold = mem_busy && !imem_ack;
    @(posedge clk);
    #1;
    if (chk_on) begin
      if (f) begin
        chk("flush_out", 32'(IF_flush_out), 32'd1);
        chk("flush_en", 32'(en), 32'd0);
        chk("flush_nop", ir_now(), NOP);
        exp_pc = ea;
      end else begin
        chk("flush_out_low", 32'(IF_flush_out), 32'd0);
        if (p_en && !s) begin
          chk("stream_pc", p_pc, exp_pc);
          chk("stream_ir", p_ir, word_at(exp_pc));
          exp_pc = exp_pc + 32'd4;
          n_consumed++;
        end else if (p_en) begin
          chk("hold_pc", IF_PC, p_pc);
          chk("hold_ir", ir_now(), p_ir);
          chk("hold_en", 32'(en), 32'd1);
        end
      end
      if (p_hold && imem_req) chk("addr_stable", imem_addr, mem_addr);
    end
  endtask

  task automatic wait_req_addr(input string tag, input logic [31:0] a);
    int k = 0;
    while (!(imem_req && imem_addr == a) && k < 40) begin
      tick(1'b0, 1'b0, 32'd0);
      k++;
    end
    chk(tag, imem_req ? imem_addr : 32'hDEAD_BEEF, a);
  endtask

  task automatic wait_ack(input string tag);
    int k = 0;
    #2;
    while (!imem_ack && k < 20) begin
      tick(1'b0, 1'b0, 32'd0);
      #2;
      k++;
    end
    chk(tag, 32'(imem_ack), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_en"}, 32'(en), 32'd0);
    chk({tag, "_flush_out"}, 32'(IF_flush_out), 32'd0);
    chk({tag, "_pc"}, IF_PC, 32'd0);
    chk({tag, "_ir"}, ir_now(), NOP);
    chk({tag, "_addr"}, imem_addr, 32'd0);
  endtask

  initial begin
    logic s_r, f_r;
    logic [31:0] ea_r;
    int k;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // first fetch with a 1-cycle memory
    rst_n = 1'b1;
    #1;
    chk("boot_req_addr", imem_req ? imem_addr : 32'hDEAD_BEEF, 32'd0);
    exp_pc = 32'd0;
    chk_on = 1'b1;
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("first_pc", IF_PC, 32'd0);
    chk("first_opcode", 32'(opcode_ID), 32'h13);
    chk("first_rd", 32'(rd_ID), 32'd1);
    chk("first_en", 32'(en), 32'd1);
    chk("next_addr4", imem_req ? imem_addr : 32'hDEAD_BEEF, 32'd4);

    // stall for three cycles across the ack at address 8
    wait_req_addr("addr8", 32'd8);
    chk("pre_stall_pc", IF_PC, 32'd4);
    tick(1'b1, 1'b0, 32'd0);
    chk("stall_req_pending", 32'(imem_req), 32'd1);
    tick(1'b1, 1'b0, 32'd0);
    chk("skid_req_low", 32'(imem_req), 32'd0);
    chk("skid_pc_held", IF_PC, 32'd4);
    tick(1'b1, 1'b0, 32'd0);
    chk("skid_req_low2", 32'(imem_req), 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("skid_word_pc", IF_PC, 32'd8);
    chk("skid_word_ir", ir_now(), word_at(32'd8));
    chk("skid_word_en", 32'(en), 32'd1);
    chk("after_skid_addr", imem_req ? imem_addr : 32'hDEAD_BEEF, 32'd12);

    // flush in the same cycle as an ack
    wait_ack("ack_for_flush");
    tick(1'b0, 1'b1, 32'h40);
    chk("flush_opcode", 32'(opcode_ID), 32'h13);
    chk("flush_addr40", imem_req ? imem_addr : 32'hDEAD_BEEF, 32'h40);
    tick(1'b0, 1'b0, 32'd0);
    chk("flush_one_cycle", 32'(IF_flush_out), 32'd0);

    // flush while a 3-cycle request at 0x10 is outstanding
    mem_lat = 3;
    tick(1'b0, 1'b1, 32'h10);
    wait_req_addr("addr10", 32'h10);
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 32'h80);
    chk("discard_req_low", 32'(imem_req), 32'd0);
    wait_req_addr("redirect80", 32'h80);
    mem_lat = 1;

    // PC wrap at the top of the address space
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_req_addr("addr_top", 32'hFFFF_FFFC);
    k = 0;
    while (!(en && IF_PC == 32'hFFFF_FFFC) && k < 20) begin
      tick(1'b0, 1'b0, 32'd0);
      k++;
    end
    chk("top_pc", IF_PC, 32'hFFFF_FFFC);
    chk("wrap_addr0", imem_req ? imem_addr : 32'hDEAD_BEEF, 32'd0);

    // reset in the middle of a 3-cycle request
    mem_lat = 3;
    tick(1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    chk_on = 1'b0;
    tick(1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reboot_req_addr", imem_req ? imem_addr : 32'hDEAD_BEEF, 32'd0);
    mem_lat = 1;
    exp_pc = 32'd0;
    chk_on = 1'b1;
    k = 0;
    while (!en && k < 20) begin
      tick(1'b0, 1'b0, 32'd0);
      k++;
    end
    chk("reboot_pc", IF_PC, 32'd0);
    chk("reboot_ir", ir_now(), 32'h0010_0093);

    // randomized stalls, redirects and memory latency
    n_consumed = 0;
    for (int i = 0; i < 400; i++) begin
      mem_lat = $urandom_range(1, 3);
      s_r = ($urandom_range(0, 3) == 0);
      f_r = ($urandom_range(0, 11) == 0);
      ea_r = 32'($urandom_range(0, 1023)) << 2;
      tick(s_r, f_r, ea_r);
    end
    chk("progress", 32'(n_consumed >= 30), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
